// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results vs. a 2-entry in-order load FIFO.
// Optional starvation guard (forced FIFO drain with ALU stall) under WB_STARVE_GUARD_EN.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        aluValid_in,
    input  logic [4:0]  aluIdx_in,
    input  logic [31:0] aluData_in,
    input  logic        ldValid_in,
    input  logic [4:0]  ldIdx_in,
    input  logic [31:0] ldData_in,
    output logic        ldReady_out,
    output logic        aluStall_out,
    output logic        writeE_out,
    output logic [4:0]  writeIdx_out,
    output logic [31:0] writeData_out
);

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_ent_t;

    if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT out of range 2..15");
    end

    wb_ent_t    fifo_q [2];
    logic       head_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       tail;

    logic       ld_acc;
    logic       ld_live;
    logic       alu_live;
    logic       drain;
    logic       deq;
    logic       enq;
    logic       direct;
    logic       sel_we;
    wb_ent_t    sel_ent;
    logic       stall_d;

    assign ldReady_out = rst_in & ~count_q[1];
    assign ld_acc      = ldValid_in & ldReady_out;
    // Index-0 results are dropped here, but the load handshake still completes.
    assign ld_live     = ld_acc & (|ldIdx_in);
    assign alu_live    = aluValid_in & (|aluIdx_in);
    assign tail        = head_q ^ count_q[0];

    always_comb begin
        sel_we  = 1'b0;
        sel_ent = fifo_q[head_q];
        deq     = 1'b0;
        direct  = 1'b0;
        if (drain) begin
            deq    = (count_q != 2'd0);
            sel_we = deq;
        end else if (alu_live) begin
            sel_we  = 1'b1;
            sel_ent = '{idx: aluIdx_in, data: aluData_in};
        end else if (count_q != 2'd0) begin
            deq    = 1'b1;
            sel_we = 1'b1;
        end else if (ld_live) begin
            direct  = 1'b1;
            sel_we  = 1'b1;
            sel_ent = '{idx: ldIdx_in, data: ldData_in};
        end
    end

    assign enq     = ld_live & ~direct;
    assign count_d = count_q + {1'b0, enq} - {1'b0, deq};

`ifdef WB_STARVE_GUARD_EN
    typedef enum logic {
        NORMAL,
        DRAIN
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] starve_q;
    logic [3:0] starve_d;

    assign drain = (state_q == DRAIN);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        stall_d  = aluStall_out;
        if (state_q == DRAIN) begin
            starve_d = '0;
            if (count_d == 2'd0) begin
                state_d = NORMAL;
                stall_d = 1'b0;
            end
        end else if (deq) begin
            starve_d = '0;
        end else if (count_q != 2'd0) begin
            starve_d = starve_q + 4'd1;
            if (starve_d == 4'(STARVE_LIMIT)) begin
                state_d = DRAIN;
                stall_d = 1'b1;
            end
        end
    end
`else
    assign drain   = 1'b0;
    assign stall_d = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            writeE_out    <= 1'b0;
            writeIdx_out  <= '0;
            writeData_out <= '0;
            aluStall_out  <= 1'b0;
            count_q       <= '0;
            head_q        <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
        end else begin
            writeE_out   <= sel_we;
            aluStall_out <= stall_d;
            count_q      <= count_d;
            if (sel_we) begin
                writeIdx_out  <= sel_ent.idx;
                writeData_out <= sel_ent.data;
            end
            if (deq) head_q <= ~head_q;
            if (enq) fifo_q[tail] <= '{idx: ldIdx_in, data: ldData_in};
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model plus directed pins.
// Honours WB_STARVE_GUARD_EN the same way as the design.
module tb_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_idx = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        alu_stall;
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wdata;

    int n_chk = 0;
    int n_fail = 0;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .aluValid_in  (alu_valid),
        .aluIdx_in    (alu_idx),
        .aluData_in   (alu_data),
        .ldValid_in   (ld_valid),
        .ldIdx_in     (ld_idx),
        .ldData_in    (ld_data),
        .ldReady_out  (ld_ready),
        .aluStall_out (alu_stall),
        .writeE_out   (we),
        .writeIdx_out (widx),
        .writeData_out(wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          starve = 0;
    bit          drain = 1'b0;
    logic        m_we = 1'b0;
    logic [4:0]  m_idx = '0;
    logic [31:0] m_data = '0;
    logic        m_stall = 1'b0;

    // Reference model: plain queue plus a waiting-cycle counter.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                starve = 0;
                drain = 1'b0;
                m_we = 1'b0;
                m_idx = '0;
                m_data = '0;
                m_stall = 1'b0;
            end else begin
                int  pre;
                bit  ld_ok, alu_ok, deq, took;
                pre    = q.size();
                ld_ok  = ld_valid && (pre < 2) && (ld_idx != 0);
                alu_ok = alu_valid && (alu_idx != 0);
                deq = 1'b0;
                took = 1'b0;
                m_we = 1'b0;
                if (drain) deq = (pre > 0);
                else if (alu_ok) begin
                    m_we = 1'b1;
                    m_idx = alu_idx;
                    m_data = alu_data;
                end else if (pre > 0) deq = 1'b1;
                else if (ld_ok) begin
                    m_we = 1'b1;
                    m_idx = ld_idx;
                    m_data = ld_data;
                    took = 1'b1;
                end
                if (deq) begin
                    m_we = 1'b1;
                    m_idx = q[0].idx;
                    m_data = q[0].data;
                    void'(q.pop_front());
                end
                if (ld_ok && !took) q.push_back('{idx: ld_idx, data: ld_data});
`ifdef WB_STARVE_GUARD_EN
                if (drain) begin
                    starve = 0;
                    if (q.size() == 0) begin
                        drain = 1'b0;
                        m_stall = 1'b0;
                    end
                end else if (deq) starve = 0;
                else if (pre > 0) begin
                    starve = starve + 1;
                    if (starve == LIMIT) begin
                        drain = 1'b1;
                        m_stall = 1'b1;
                    end
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            logic m_rdy;
            @(negedge clk);
            m_rdy = rst_n && (q.size() < 2);
            chk("cmp_we", we, m_we);
            chk("cmp_idx", widx, m_idx);
            chk("cmp_data", wdata, m_data);
            chk("cmp_stall", alu_stall, m_stall);
            chk("cmp_ready", ld_ready, m_rdy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] i,
                             input logic [31:0] d);
        alu_valid = v;
        alu_idx = i;
        alu_data = d;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] i,
                            input logic [31:0] d);
        ld_valid = v;
        ld_idx = i;
        ld_data = d;
    endtask

    task automatic chk_wr(input string name, input logic e,
                          input logic [4:0] i, input logic [31:0] d);
        chk({name, "_we"}, we, e);
        chk({name, "_idx"}, widx, i);
        chk({name, "_data"}, wdata, d);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_wr("rst", 0, 0, 0);
        chk("rst_stall", alu_stall, 0);
        chk("rst_ready", ld_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", ld_ready, 1);
        tick();

        drive_ld(1, 5, 32'hDEADBEEF);
        tick();
        drive_ld(0, 0, 0);
        chk_wr("idle_ld", 1, 5, 32'hDEADBEEF);
        chk("idle_ld_rdy", ld_ready, 1);
        tick();
        chk_wr("idle_hold", 0, 5, 32'hDEADBEEF);

        drive_alu(1, 3, 32'h11);
        drive_ld(1, 7, 32'h22);
        tick();
        drive_alu(0, 0, 0);
        drive_ld(0, 0, 0);
        chk_wr("coll_alu", 1, 3, 32'h11);
        tick();
        chk_wr("coll_ld", 1, 7, 32'h22);
        tick();
        chk_wr("coll_hold", 0, 7, 32'h22);

        drive_alu(1, 1, 32'hA1);
        drive_ld(1, 11, 32'hB1);
        tick();
        chk_wr("full_a", 1, 1, 32'hA1);
        drive_alu(1, 2, 32'hA2);
        drive_ld(1, 12, 32'hB2);
        tick();
        chk_wr("full_b", 1, 2, 32'hA2);
        chk("full_rdy0", ld_ready, 0);
        drive_alu(1, 4, 32'hA3);
        drive_ld(1, 13, 32'hB3);
        tick();
        chk_wr("full_c", 1, 4, 32'hA3);
        chk("full_rdy1", ld_ready, 0);
        drive_alu(0, 0, 0);
        tick();
        chk_wr("full_l1", 1, 11, 32'hB1);
        chk("full_rdy2", ld_ready, 1);
        tick();
        drive_ld(0, 0, 0);
        chk_wr("full_l2", 1, 12, 32'hB2);
        tick();
        chk_wr("full_l3", 1, 13, 32'hB3);
        chk("full_rdy3", ld_ready, 1);
        tick();
        chk("full_idle", we, 0);

        drive_alu(1, 0, 32'h55);
        drive_ld(1, 0, 32'h66);
        chk("z_rdy_pre", ld_ready, 1);
        tick();
        drive_alu(0, 0, 0);
        drive_ld(0, 0, 0);
        chk("z_we", we, 0);
        chk("z_rdy", ld_ready, 1);
        tick();
        chk("z_we2", we, 0);

        drive_alu(1, 9, 32'h90);
        drive_ld(1, 10, 32'hAB);
        tick();
        drive_ld(0, 0, 0);
        chk_wr("sv_0", 1, 9, 32'h90);
        for (int k = 1; k <= LIMIT; k++) begin
            drive_alu(1, 9, k);
            tick();
            chk("sv_alu", wdata, k);
`ifdef WB_STARVE_GUARD_EN
            chk("sv_stall", alu_stall, k == LIMIT);
`else
            chk("sv_stall", alu_stall, 0);
`endif
        end
        drive_alu(1, 9, 32'h99);
        tick();
`ifdef WB_STARVE_GUARD_EN
        chk_wr("sv_drain", 1, 10, 32'hAB);
        chk("sv_unstall", alu_stall, 0);
        drive_alu(0, 0, 0);
        tick();
`else
        chk_wr("sv_wait", 1, 9, 32'h99);
        chk("sv_nostall", alu_stall, 0);
        drive_alu(0, 0, 0);
        tick();
        chk_wr("sv_late", 1, 10, 32'hAB);
`endif
        tick();

        drive_alu(1, 1, 32'hC1);
        drive_ld(1, 20, 32'hD0);
        tick();
        drive_alu(1, 2, 32'hC2);
        drive_ld(1, 21, 32'hD1);
        tick();
        drive_alu(0, 0, 0);
        drive_ld(0, 0, 0);
        chk("mr_rdy", ld_ready, 0);
        rst_n = 1'b0;
        #1;
        chk_wr("mr_rst", 0, 0, 0);
        chk("mr_stall", alu_stall, 0);
        chk("mr_rdy0", ld_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_rel", ld_ready, 1);
        drive_ld(1, 6, 32'h77);
        tick();
        drive_ld(0, 0, 0);
        chk_wr("mr_first", 1, 6, 32'h77);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_nowr", we, 0);
        end

        for (int c = 0; c < 3000; c++) begin
            drive_alu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                      $urandom);
            drive_ld($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)),
                     $urandom);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            tick();
        end
        drive_alu(0, 0, 0);
        drive_ld(0, 0, 0);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning cycles a buffered load may wait before the ALU is stalled (legal range 2..15).
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port aluValid_in, input, 1, ALU result present this cycle; no backpressure.
REQ-005 SHALL have port aluIdx_in, input, 5, ALU destination register index.
REQ-006 SHALL have port aluData_in, input, 32, ALU result value.
REQ-007 SHALL have port ldValid_in, input, 1, load result offered.
REQ-008 SHALL have port ldIdx_in, input, 5, load destination register index.
REQ-009 SHALL have port ldData_in, input, 32, load result value.
REQ-010 SHALL have port ldReady_out, output, 1, load result accepted when ldValid_in and ldReady_out are both high at a clock edge.
REQ-011 SHALL have port aluStall_out, output, 1, upstream must hold and not present ALU results.
REQ-012 SHALL have port writeE_out, output, 1, register-file write enable.
REQ-013 SHALL have port writeIdx_out, output, 5, register-file write index.
REQ-014 SHALL have port writeData_out, output, 32, register-file write data.

Function
REQ-015 SHALL register writeE_out, writeIdx_out, writeData_out and aluStall_out; a result selected in cycle N appears on the write port in cycle N+1 for exactly one cycle.
REQ-016 SHALL contain a 2-entry in-order load FIFO; ldReady_out = (count < 2) and not in reset, combinational from count.
REQ-017 SHALL select per cycle, highest priority first: FIFO head in DRAIN state; ALU when aluValid_in; FIFO head when count > 0; incoming load directly when FIFO empty and accepted; else writeE_out = 0 next cycle.
REQ-018 SHALL enqueue an accepted load that is not selected directly; simultaneous dequeue and enqueue at count 1 leaves count 1 with order preserved.
REQ-019 SHALL discard results with index 0 at input: index-0 ALU results produce no write; index-0 loads are accepted (handshake completes) but never enqueued or written.
REQ-020 SHALL never reorder loads; the direct path is used only when the FIFO is empty.
REQ-021 SHALL keep writeIdx_out/writeData_out at their previous values when writeE_out is 0.

Reset
REQ-022 SHALL, while rst_in is low, asynchronously force writeE_out = 0, writeIdx_out = 0, writeData_out = 0, aluStall_out = 0, ldReady_out = 0, FIFO count = 0, starvation counter = 0, state = NORMAL.
REQ-023 SHALL discard FIFO contents on reset asserted mid-operation; no buffered load is written after reset release.
REQ-024 SHALL raise ldReady_out combinationally when rst_in goes high, accepting a load on the first edge after release.

Configuration
REQ-025 SHALL implement the starvation guard only when macro WB_STARVE_GUARD_EN is defined.
REQ-026 SHALL, with WB_STARVE_GUARD_EN: states NORMAL/DRAIN; in NORMAL increment counter each cycle count > 0 and head not dequeued, clear it on any dequeue; on reaching STARVE_LIMIT enter DRAIN and set aluStall_out = 1 next cycle; in DRAIN ignore aluValid_in and dequeue one entry per cycle; return to NORMAL, clear aluStall_out and counter in the cycle the FIFO becomes empty with no enqueue.
REQ-027 SHALL, without WB_STARVE_GUARD_EN: no counter or state, aluStall_out tied 0, ALU always outranks FIFO.

Verification
REQ-028 SHALL verify idle load: count 0, ALU idle, ldValid_in = 1, ldIdx_in = 5, ldData_in = 0xDEADBEEF -> next cycle writeE_out = 1, writeIdx_out = 5, writeData_out = 0xDEADBEEF; count stays 0.
REQ-029 SHALL verify collision: aluValid_in = 1 (idx 3, 0x11) with load (idx 7, 0x22) same cycle -> cycle N+1 writes x3 = 0x11, cycle N+2 writes x7 = 0x22 when ALU is idle.
REQ-030 SHALL verify full FIFO: ALU valid every cycle, three consecutive loads -> ldReady_out = 0 after two accepts; third load held until a slot frees; order preserved.
REQ-031 SHALL verify index 0: ALU idx 0 and load idx 0 -> writeE_out stays 0, load handshake completes, count 0.
REQ-032 SHALL verify guard (macro defined, STARVE_LIMIT = 4): one buffered load with ALU valid continuously -> aluStall_out = 1 after 4 waiting cycles, load written next cycle, aluStall_out = 0 once FIFO empties; macro undefined -> load waits indefinitely, aluStall_out = 0.
REQ-033 SHALL verify reset mid-operation: FIFO at count 2, rst_in low for one cycle -> all outputs 0 immediately, no buffered load ever written.
